// File: rtl/vga_wr_pkg.sv
// Shared definitions for the VGA PIO write bridge.
// FB_* give the framebuffer geometry. vga_wr_t is the buffered write word,
// an {addr, data} pair.
package vga_wr_pkg;

   localparam int unsigned FB_H_RES   = 640;
   localparam int unsigned FB_V_RES   = 480;
   localparam int unsigned FB_PIXELS  = FB_H_RES * FB_V_RES;
   localparam int unsigned VGA_ADDR_W = 19;
   localparam int unsigned VGA_DATA_W = 8;

   typedef struct packed {
      logic [VGA_ADDR_W-1:0] addr;
      logic [VGA_DATA_W-1:0] data;
   } vga_wr_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push, din     write request and word (ignored when full and not popping)
//   pop           read request (ignored when empty)
//   head          registered head word; holds the last head while empty
//   full, empty   derived from pointers carrying one extra wrap bit
//   level         occupancy, 0..DEPTH
module vga_wr_fifo
   import vga_wr_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type word_t = vga_wr_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  word_t                    din,
   input  logic                     pop,
   output word_t                    head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   word_t              mem [DEPTH];
   word_t              head_q;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   level_q;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic [PTR_W-1:0]   level_nxt;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_nxt_idx;
   logic               do_push;
   logic               do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

   assign do_pop     = pop & ~empty;
   assign do_push    = push & (~full | do_pop);
   assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
   assign level_nxt  = level_q + PTR_W'(do_push) - PTR_W'(do_pop);
   assign wr_idx     = wr_ptr[IDX_W-1:0];
   assign rd_nxt_idx = rd_ptr_nxt[IDX_W-1:0];

   // The head register looks one cycle ahead. A word written this cycle into
   // the next head slot bypasses the memory. When the FIFO drains, the head
   // register keeps its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem     <= '{default: '0};
         head_q  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) mem[wr_idx] <= din;
         wr_ptr  <= wr_ptr + PTR_W'(do_push);
         rd_ptr  <= rd_ptr_nxt;
         level_q <= level_nxt;
         if (level_nxt != '0)
            head_q <= (do_push && (wr_idx == rd_nxt_idx)) ? din : mem[rd_nxt_idx];
      end
   end

   assign head  = head_q;
   assign level = level_q;

endmodule

// File: rtl/vga_pio_write_bridge.sv
// Converts HPS PIO pixel writes into single-beat valid/ready framebuffer writes.
// Each rising edge of the write enable produces one write. A write is dropped
// if its address is outside the framebuffer (counted in range_err_cnt_o) or if
// the FIFO is full with no pop that cycle (counted in overflow_cnt_o). Both
// counters saturate.
// Ports:
//   clk_clk, reset_reset                     clock, asynchronous active-high reset
//   pio_addr_i, pio_data_i, pio_we_i         PIO exports from soc_system
//   fb_addr_o, fb_data_o, fb_valid_o         framebuffer request (FIFO head)
//   fb_ready_i                               framebuffer accept
//   fifo_level_o, busy_o                     FIFO occupancy and non-empty flag
//   overflow_cnt_o, range_err_cnt_o          saturating drop counters
// Defining VGA_WR_BRIDGE_SYNC_EN adds a 2-flop synchronizer on pio_we_i. Use it
// when the PIO is in another clock domain.
module vga_pio_write_bridge #(
   parameter int unsigned ADDR_W     = vga_wr_pkg::VGA_ADDR_W,
   parameter int unsigned DATA_W     = vga_wr_pkg::VGA_DATA_W,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FB_PIXELS  = vga_wr_pkg::FB_PIXELS,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [ADDR_W-1:0]             pio_addr_i,
   input  logic [DATA_W-1:0]             pio_data_i,
   input  logic                          pio_we_i,
   output logic [ADDR_W-1:0]             fb_addr_o,
   output logic [DATA_W-1:0]             fb_data_o,
   output logic                          fb_valid_o,
   input  logic                          fb_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic [CNT_W-1:0]              overflow_cnt_o,
   output logic [CNT_W-1:0]              range_err_cnt_o
);

   import vga_wr_pkg::*;

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              we_s;
   logic              we_q;
   logic              wr_evt;
   logic              in_range;
   logic              pop;
   logic              push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  level;
   logic [CNT_W-1:0]  ovf_cnt_q;
   logic [CNT_W-1:0]  rerr_cnt_q;
   vga_wr_t           wr_word;
   vga_wr_t           head;

`ifdef VGA_WR_BRIDGE_SYNC_EN
   logic [1:0] we_sync_q;

   // The synchronizer resets high so that a write enable held high across reset release produces no write.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) we_sync_q <= 2'b11;
      else             we_sync_q <= {we_sync_q[0], pio_we_i};
   end
   assign we_s = we_sync_q[1];
`else
   assign we_s = pio_we_i;
`endif

   // Write-enable history, reset high for the same reason.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) we_q <= 1'b1;
      else             we_q <= we_s;
   end

   assign wr_evt   = we_s & ~we_q;
   assign in_range = 32'(pio_addr_i) < 32'(FB_PIXELS);
   assign pop      = fb_valid_o & fb_ready_i;
   // A full FIFO still accepts a write in a cycle where it pops.
   assign push     = wr_evt & in_range & (~fifo_full | pop);

   assign wr_word.addr = VGA_ADDR_W'(pio_addr_i);
   assign wr_word.data = VGA_DATA_W'(pio_data_i);

   vga_wr_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .word_t (vga_wr_t)
   ) u_fifo (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .push  (push),
      .din   (wr_word),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Drop counters. The range check has priority over the overflow check.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         ovf_cnt_q  <= '0;
         rerr_cnt_q <= '0;
      end else begin
         if (wr_evt && !in_range && (rerr_cnt_q != '1))
            rerr_cnt_q <= rerr_cnt_q + CNT_W'(1);
         if (wr_evt && in_range && fifo_full && !pop && (ovf_cnt_q != '1))
            ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
      end
   end

   assign fb_addr_o       = ADDR_W'(head.addr);
   assign fb_data_o       = DATA_W'(head.data);
   assign fb_valid_o      = ~fifo_empty;
   assign fifo_level_o    = level;
   assign busy_o          = (level != '0);
   assign overflow_cnt_o  = ovf_cnt_q;
   assign range_err_cnt_o = rerr_cnt_q;

endmodule

// File: tb/tb_vga_pio_write_bridge.sv
// Bench for vga_pio_write_bridge. The reference model is a queue of {addr, data}
// writes plus a pair of saturating drop counters.
module tb_vga_pio_write_bridge;
   import vga_wr_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;
   localparam int unsigned CMAX  = (1 << CW) - 1;
   localparam int unsigned NPIX  = FB_PIXELS;

   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] addr;
   logic [7:0]  data;
   logic        we;
   logic        ready;
   logic [18:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_valid;
   logic [3:0]  level;
   logic        busy;
   logic [CW-1:0] ovf_cnt;
   logic [CW-1:0] rerr_cnt;

   vga_pio_write_bridge #(.CNT_W(CW)) dut (
      .clk_clk         (clk),
      .reset_reset     (rst),
      .pio_addr_i      (addr),
      .pio_data_i      (data),
      .pio_we_i        (we),
      .fb_addr_o       (fb_addr),
      .fb_data_o       (fb_data),
      .fb_valid_o      (fb_valid),
      .fb_ready_i      (ready),
      .fifo_level_o    (level),
      .busy_o          (busy),
      .overflow_cnt_o  (ovf_cnt),
      .range_err_cnt_o (rerr_cnt)
   );

   always #5 clk = ~clk;

   // Reference model state
   int unsigned qa[$];
   int unsigned qd[$];
   int unsigned last_a, last_d, exp_ovf, exp_rerr;
   bit          we_prev, s1, s2;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      qa.delete();
      qd.delete();
      last_a = 0; last_d = 0; exp_ovf = 0; exp_rerr = 0;
      we_prev = 1'b1; s1 = 1'b1; s2 = 1'b1;
   endtask

   // One clock edge of the model. It uses the inputs that are stable before the edge.
   task automatic model_edge();
      bit evt, do_pop;
      int unsigned size_pre;
      if (rst) return;
      size_pre = qa.size();
      do_pop   = (size_pre > 0) && ready;
`ifdef VGA_WR_BRIDGE_SYNC_EN
      evt = s2 && !we_prev;
      we_prev = s2; s2 = s1; s1 = we;
`else
      evt = we && !we_prev;
      we_prev = we;
`endif
      if (do_pop) begin
         last_a = qa.pop_front();
         last_d = qd.pop_front();
      end
      if (evt) begin
         if (int'(addr) >= int'(NPIX)) begin
            if (exp_rerr < CMAX) exp_rerr++;
         end else if (size_pre == DEPTH && !do_pop) begin
            if (exp_ovf < CMAX) exp_ovf++;
         end else begin
            qa.push_back(int'(addr));
            qd.push_back(int'(data));
         end
      end
   endtask

   task automatic check_all();
      bit v;
      v = qa.size() > 0;
      chk("valid", 32'(fb_valid), 32'(v));
      chk("level", 32'(level), 32'(qa.size()));
      chk("busy",  32'(busy),  32'(v));
      chk("addr",  32'(fb_addr), v ? qa[0] : last_a);
      chk("data",  32'(fb_data), v ? qd[0] : last_d);
      chk("ovf_cnt",  32'(ovf_cnt),  exp_ovf);
      chk("rerr_cnt", 32'(rerr_cnt), exp_rerr);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic wr(input int unsigned a, input int unsigned d);
      addr = 19'(a);
      data = 8'(d);
      we   = 1'b1;
      tick();
      we   = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; ready = 1'b0; addr = '0; data = '0;
      model_reset();
      #1;
      check_all();
      #22 rst = 1'b0;

      // Single write, we held high for 4 cycles
      ready = 1'b1; addr = 19'h00123; data = 8'hA5; we = 1'b1;
      repeat (4) tick();
      we = 1'b0;
      repeat (4) tick();

      // Backpressure: 8 buffered writes, the 9th overflows, then drain
      ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(32'h100 + i, i);
      wr(32'h200, 8'h99);
      ready = 1'b1;
      repeat (10) tick();

      // Range boundary
      wr(NPIX, 8'h11);
      wr(NPIX - 1, 8'h22);
      repeat (3) tick();

      // Full FIFO plus an out-of-range address
      ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(32'h300 + i, 8'h30 + i);
      wr(NPIX + 5, 8'h44);
      // Full FIFO with a push and a pop in the same cycle
      addr = 19'h00555; data = 8'hEE; ready = 1'b1; we = 1'b1;
      tick();
      we = 1'b0;
      repeat (12) tick();

      // Reset asserted mid-stream, we held high across release
      ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(32'h400 + i, 8'h40 + i);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("rst_valid", 32'(fb_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      #4 we = 1'b1; ready = 1'b1; addr = 19'h00777; data = 8'h77;
      #8 rst = 1'b0;
      repeat (4) tick();
      we = 1'b0;
      tick();
      we = 1'b1;
      repeat (5) tick();
      we = 1'b0;
      tick();

      // Overflow counter saturation
      ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(32'h500 + i, i);
      for (int i = 0; i < 20; i++) wr(32'h600 + i, i);
      chk("ovf_sat", 32'(ovf_cnt), 32'(CMAX));
      ready = 1'b1;
      repeat (12) tick();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         we    = ($urandom_range(0, 2) == 0);
         ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         addr  = ($urandom_range(0, 9) == 0) ? 19'(NPIX + $urandom_range(0, 50))
                                             : 19'($urandom_range(0, NPIX - 1));
         data  = 8'($urandom);
         tick();
      end
      we = 1'b0; ready = 1'b1;
      repeat (12) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_pio_write_bridge.md
Name: vga_pio_write_bridge

Overview:
Downstream consumer of the soc_system VGA PIO exports (pio_vga_addr/data/we). It turns HPS software-driven PIO writes into single-beat framebuffer write requests with a valid/ready handshake. Each write is edge-detected on the write-enable, range-checked against the framebuffer size, and buffered in a small FIFO so that memory-side backpressure does not lose pixels. It sits between soc_system and the framebuffer RAM/arbiter in the top level.

Parameters:
ADDR_W, 19, pixel address width (matches pio_vga_addr export)
DATA_W, 8, pixel data width (matches pio_vga_data export)
FIFO_DEPTH, 8, buffered writes; power of two, >=2
FB_PIXELS, 307200, valid address range is 0..FB_PIXELS-1 (640x480)
CNT_W, 16, width of the saturating error counters

Ports:
clk_clk  in  1  system clock; same domain as soc_system
reset_reset  in  1  asynchronous, active-high reset
pio_addr_i  in  ADDR_W  from pio_vga_addr_external_connection_export
pio_data_i  in  DATA_W  from pio_vga_data_external_connection_export
pio_we_i  in  1  from pio_vga_we_external_connection_export
fb_addr_o  out  ADDR_W  framebuffer write address (FIFO head)
fb_data_o  out  DATA_W  framebuffer write data (FIFO head)
fb_valid_o  out  1  write request valid
fb_ready_i  in  1  framebuffer accepts the beat when valid&ready
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy
busy_o  out  1  FIFO non-empty
overflow_cnt_o  out  CNT_W  writes dropped because the FIFO was full, saturating
range_err_cnt_o  out  CNT_W  writes dropped because addr >= FB_PIXELS, saturating

Behaviour:
- Reset: all outputs are 0. FIFO is flushed and the pointers are cleared. Counters are cleared. The we_q history register resets to 1, so a we held high across reset release produces no write.
- Edge detect: wr_evt = pio_we_i & ~we_q; we_q <= pio_we_i every cycle. Exactly one event per 0->1 transition, regardless of how long we stays high.
- On wr_evt in cycle N, addr/data are sampled in cycle N:
  - addr >= FB_PIXELS: drop; range_err_cnt_o +1 (saturates at all-ones). The range check has priority over the overflow check.
  - FIFO full and no pop in cycle N: drop; overflow_cnt_o +1 (saturating).
  - Otherwise push.
- Full with simultaneous pop (fb_valid_o & fb_ready_i): the push is accepted and the level is unchanged.
- Output is first-word-fall-through from registered FIFO state. A push into an empty FIFO at cycle N gives fb_valid_o=1 at cycle N+1.
- While fb_valid_o & ~fb_ready_i, fb_addr_o and fb_data_o stay stable. Pop occurs on valid&ready.
- Empty: fb_valid_o=0; fb_addr_o and fb_data_o hold the last head value (0 after reset).
- Pointers are ADDR-indexed modulo FIFO_DEPTH and wrap naturally. Full/empty use an extra pointer bit.
- busy_o = (level != 0). fifo_level_o updates the cycle after push/pop.
- Reset asserted mid-operation: queued writes are discarded immediately (async) and all outputs go to 0.

Optional Feature:
VGA_WR_BRIDGE_SYNC_EN
- Defined: pio_we_i passes through a 2-flop synchronizer (reset to 1) before edge detection. addr/data are sampled on the synchronized edge. Software must hold addr/data stable while we is high. Push-to-valid latency becomes N+3 from the raw we rise. Use this when the PIO sits in another clock domain.
- Undefined: raw pio_we_i is edge-detected directly, latency N+1, no synchronizer flops.

Decomposition:
- Package vga_wr_pkg: FB_H_RES=640, FB_V_RES=480, FB_PIXELS, VGA_ADDR_W=19, VGA_DATA_W=8, and the packed struct vga_wr_t {addr, data} used as the FIFO word.
- Sub-module vga_wr_fifo: synchronous FWFT FIFO with push/pop/full/empty/level, parameterized by depth and word type.

Test Plan:
- Single write: addr=0x00123, data=0xA5, we held high 4 cycles, fb_ready_i=1 -> exactly one beat, fb_valid_o high 1 cycle at N+1 with addr 0x00123, data 0xA5; counters stay 0.
- Backpressure: fb_ready_i=0, 8 writes (data 0..7) -> level=8, busy_o=1; 9th write -> overflow_cnt_o=1; then fb_ready_i=1 -> 8 beats, data 0..7 in order, addr/data stable while stalled.
- Range: write addr=307200 -> no beat, range_err_cnt_o=1; write addr=307199 -> accepted beat. Full FIFO plus out-of-range addr -> range_err_cnt increments, overflow does not.
- Full plus simultaneous pop: level=8, fb_ready_i=1, new write in the same cycle -> accepted, level stays 8, overflow_cnt_o=0, new word emerges last.
- Reset: 3 writes queued, assert reset_reset mid-stream -> fb_valid_o=0, level=0, counters 0 immediately; we high across release -> no beat until we falls and rises again.
- Saturation with CNT_W=4: 20 overflow drops -> overflow_cnt_o=15 and holds. With VGA_WR_BRIDGE_SYNC_EN defined, the single-write case shows valid at N+3.
